// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms a run, aligns to frame boundaries and gates capture of N frames
// Ports: clk, reset (async, active-low); arm/abort/num_frames run control;
//   aligned_valid, fr_active, fr_valid from the byte aligner and packet handler;
//   ph_din_valid, capture_en gating; busy, done, timeout_err status;
//   frames_done, line_count, frame_words progress counters.
module frame_capture_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter int          CNT_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic [7:0]       num_frames,
  input  logic             aligned_valid,
  input  logic             fr_active,
  input  logic             fr_valid,
  output logic             ph_din_valid,
  output logic             capture_en,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [7:0]       frames_done,
  output logic [15:0]      line_count,
  output logic [CNT_W-1:0] frame_words
);
  typedef enum logic [2:0] {IDLE, SYNC, WAIT_FS, CAPTURE, DONE} state_t;
  state_t      state;
  logic [7:0]  nf;
  logic [15:0] tcnt;
  logic        fa_d, fv_d;
  logic [7:0]  fd_next;
  logic        fa_fall, fv_fall, act, tmo;
  // act marks the activity that keeps the watchdog quiet in the current state
  always_comb begin
    fd_next = frames_done + 8'd1;
    fa_fall = fa_d & ~fr_active;
    fv_fall = fv_d & ~fr_valid;
    act     = (state == CAPTURE) ? fr_valid : (fr_active ^ fa_d);
    tmo     = ~act & (tcnt == TIMEOUT - 16'd1);
  end
  assign ph_din_valid = (state != IDLE) & aligned_valid;
  assign capture_en   = (state == CAPTURE) & fr_valid;
  assign busy         = state != IDLE;
  assign done         = state == DONE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      nf          <= '0;
      tcnt        <= '0;
      fa_d        <= 1'b0;
      fv_d        <= 1'b0;
      timeout_err <= 1'b0;
      frames_done <= '0;
      line_count  <= '0;
      frame_words <= '0;
    end else begin
      fa_d <= fr_active;
      fv_d <= fr_valid;
      tcnt <= act ? '0 : tcnt + 16'd1;
      if (state != IDLE && abort) begin
        state <= IDLE;
        tcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            tcnt <= '0;
            if (arm && !abort) begin
              nf          <= num_frames;
              frames_done <= '0;
              line_count  <= '0;
              frame_words <= '0;
              timeout_err <= 1'b0;
              state       <= SYNC;
            end
          end
          // never start mid-frame: wait for the current frame to end first
          SYNC: begin
            if (!fr_active) begin
              state <= WAIT_FS;
              tcnt  <= '0;
            end else if (tmo) begin
              state       <= IDLE;
              tcnt        <= '0;
              timeout_err <= 1'b1;
            end
          end
          WAIT_FS: begin
            if (fr_active) begin
              state       <= CAPTURE;
              tcnt        <= '0;
              line_count  <= '0;
              frame_words <= '0;
            end else if (tmo) begin
              state       <= IDLE;
              tcnt        <= '0;
              timeout_err <= 1'b1;
            end
          end
          CAPTURE: begin
            if (fr_valid && frame_words != '1) frame_words <= frame_words + 1'b1;
            if (fv_fall) line_count <= line_count + 16'd1;
            // frame end takes priority over a coincident timeout
            if (fa_fall) begin
              frames_done <= fd_next;
              state       <= (nf != 8'd0 && fd_next == nf) ? DONE : WAIT_FS;
              tcnt        <= '0;
            end else if (tmo) begin
              state       <= IDLE;
              tcnt        <= '0;
              timeout_err <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: scoreboard bench for frame_capture_ctrl run outcomes and gating
module tb_frame_capture_ctrl;
  logic        clk = 1'b0, reset = 1'b0, arm = 1'b0, abort = 1'b0;
  logic [7:0]  num_frames = 8'd0;
  logic        aligned_valid = 1'b0, fr_active = 1'b0, fr_valid = 1'b0;
  logic        ph_din_valid, capture_en, busy, done, timeout_err;
  logic [7:0]  frames_done;
  logic [15:0] line_count;
  logic [23:0] frame_words;
  int tests = 0, fails = 0;
  typedef struct {
    string name;
    int done_n, frames, lines, words, tmo, cap, bcyc;
  } exp_t;
  exp_t q[$];
  int mon_busy = 0, mon_done = 0, mon_cap = 0;
  logic busy_prev = 1'b0;
  frame_capture_ctrl #(.TIMEOUT(16'd100), .CNT_W(24)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .num_frames(num_frames),
    .aligned_valid(aligned_valid), .fr_active(fr_active), .fr_valid(fr_valid),
    .ph_din_valid(ph_din_valid), .capture_en(capture_en), .busy(busy), .done(done),
    .timeout_err(timeout_err), .frames_done(frames_done), .line_count(line_count),
    .frame_words(frame_words)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic expect_run(input string n, input int d, input int f, input int l,
                            input int w, input int t, input int c, input int b);
    exp_t e;
    e.name = n; e.done_n = d; e.frames = f; e.lines = l;
    e.words = w; e.tmo = t; e.cap = c; e.bcyc = b;
    q.push_back(e);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic line(input int w);
    fr_valid = 1'b1;
    repeat (w) tick();
    fr_valid = 1'b0;
    repeat (2) tick();
  endtask
  task automatic frame(input int l, input int w);
    fr_active = 1'b1;
    repeat (2) tick();
    repeat (l) line(w);
    fr_active = 1'b0;
    repeat (2) tick();
  endtask
  task automatic start(input logic [7:0] n);
    num_frames = n;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 400) begin
      tick();
      k++;
    end
    chk({name, "_idle_bound"}, int'(busy), 0);
  endtask
  // monitor: accumulates per-run activity and checks it when busy falls
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) mon_busy++;
      if (done) mon_done++;
      if (capture_en) mon_cap++;
      if (busy_prev && !busy) begin
        if (q.size() == 0) chk("unexpected_run_end", 1, 0);
        else begin
          e = q.pop_front();
          chk({e.name, "_done_pulses"}, mon_done, e.done_n);
          chk({e.name, "_frames_done"}, int'(frames_done), e.frames);
          chk({e.name, "_line_count"}, int'(line_count), e.lines);
          chk({e.name, "_frame_words"}, int'(frame_words), e.words);
          chk({e.name, "_timeout_err"}, int'(timeout_err), e.tmo);
          if (e.cap >= 0) chk({e.name, "_capture_words"}, mon_cap, e.cap);
          if (e.bcyc >= 0) chk({e.name, "_busy_cycles"}, mon_busy, e.bcyc);
        end
        mon_busy = 0;
        mon_done = 0;
        mon_cap = 0;
      end
      busy_prev = busy;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    aligned_valid = 1'b1;
    fr_valid = 1'b1;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_frames_done", int'(frames_done), 0);
    chk("rst_line_count", int'(line_count), 0);
    chk("rst_frame_words", int'(frame_words), 0);
    chk("rst_ph_din_valid", int'(ph_din_valid), 0);
    chk("rst_capture_en", int'(capture_en), 0);
    aligned_valid = 1'b0;
    fr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    // two frames of 4 lines x 16 words; a stray arm mid-run must be ignored
    expect_run("two_frames", 1, 2, 4, 64, 0, 128, -1);
    start(8'd2);
    tick();
    frame(4, 16);
    start(8'd5);
    frame(4, 16);
    wait_idle("two_frames");
    // armed mid-frame: partial frame is skipped
    expect_run("mid_frame_arm", 1, 1, 3, 30, 0, 30, -1);
    fr_active = 1'b1;
    tick();
    start(8'd1);
    line(5);
    line(5);
    fr_active = 1'b0;
    repeat (2) tick();
    frame(3, 10);
    wait_idle("mid_frame_arm");
    // no frame ever starts: 1 SYNC cycle + 100 WAIT_FS cycles then timeout
    expect_run("timeout", 0, 0, 0, 0, 1, 0, 101);
    start(8'd1);
    wait_idle("timeout");
    repeat (2) tick();
    chk("timeout_sticky", int'(timeout_err), 1);
    // continuous mode, three frames then abort
    expect_run("continuous_abort", 0, 3, 2, 8, 0, 24, -1);
    start(8'd0);
    chk("timeout_cleared_by_arm", int'(timeout_err), 0);
    tick();
    repeat (3) frame(2, 4);
    aligned_valid = 1'b1;
    tick();
    chk("ph_din_valid_busy", int'(ph_din_valid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ph_din_valid_after_abort", int'(ph_din_valid), 0);
    chk("busy_after_abort", int'(busy), 0);
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_idle_0", int'(busy), 0);
    tick();
    chk("arm_abort_idle_1", int'(busy), 0);
    aligned_valid = 1'b0;
    // asynchronous reset in the middle of a line
    expect_run("reset_mid_line", 0, 0, 0, 0, 0, -1, -1);
    start(8'd1);
    tick();
    fr_active = 1'b1;
    repeat (2) tick();
    fr_valid = 1'b1;
    aligned_valid = 1'b1;
    repeat (3) tick();
    chk("pre_reset_words", int'(frame_words), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_frame_words", int'(frame_words), 0);
    chk("async_ph_din_valid", int'(ph_din_valid), 0);
    chk("async_capture_en", int'(capture_en), 0);
    fr_valid = 1'b0;
    fr_active = 1'b0;
    aligned_valid = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_after_release", int'(busy), 0);
    end
    // idle gating with active-looking inputs
    for (int i = 0; i < 8; i++) begin
      aligned_valid = i[0];
      fr_valid = ~i[0];
      fr_active = i[1];
      tick();
      chk("idle_ph_din_valid", int'(ph_din_valid), 0);
      chk("idle_capture_en", int'(capture_en), 0);
    end
    fr_active = 1'b0;
    fr_valid = 1'b0;
    aligned_valid = 1'b0;
    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
